axi_sram_slave: RTL and testbench

AXI4 slave memory model answering the `io_master_*` requests of the core's AXI master interface, which handles IFU fetch and LSU load/store. It sits directly downstream of that interface as its memory target in simulation and FPGA builds. It has independent read and write channels, INCR/FIXED bursts, a programmable read latency, and a byte-strobed 32-bit word array.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/sram_byte_array.sv | 29 ++
 rtl/axi_sram_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state types for the SRAM slave model.
// Imported by axi_sram_slave; no ports.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/sram_byte_array.sv
// Word array with one byte-enabled write port and one async read port.
// Ports: clk_i, we_i, waddr_i, wbe_i, wdata_i, raddr_i, rdata_o.
module sram_byte_array #(
  parameter int DEPTH_WORDS = 4096,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [3:0]    wbe_i,
  input  logic [31:0]   wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Contents survive reset, so the array has no reset term.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave SRAM model: independent read/write FSMs, INCR/FIXED bursts.
// Ports: clock, reset (async low), io_slave_aw/w/b/ar/r channel signals.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LATENCY  = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  rd_state_e   rs_q, rs_d;
  wr_state_e   ws_q, ws_d;
  logic        alive_q;
  logic [31:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [3:0]  rid_q, rid_d, wid_q, wid_d;
  logic [7:0]  rlen_q, rlen_d, wlen_q, wlen_d;
  logic [7:0]  rcnt_q, rcnt_d, wcnt_q, wcnt_d;
  logic [1:0]  rburst_q, rburst_d, wburst_q, wburst_d;
  logic [3:0]  rlat_q, rlat_d;
  logic        werr_q, werr_d;

  logic [31:0] roff, woff, mem_rdata;
  logic        r_ok, w_ok, w_last, mem_we;

  // Unsigned wrap makes addresses below BASE_ADDR land out of range.
  assign roff = raddr_q - BASE_ADDR;
  assign woff = waddr_q - BASE_ADDR;
  assign r_ok = roff < SPAN;
  assign w_ok = woff < SPAN;

  logic unused_bits;
  assign unused_bits = ^{io_slave_awsize, io_slave_arsize,
                         roff[31:IW+2], roff[1:0],
                         woff[31:IW+2], woff[1:0]};

  sram_byte_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clock),
    .we_i   (mem_we),
    .waddr_i(woff[IW+1:2]),
    .wbe_i  (io_slave_wstrb),
    .wdata_i(io_slave_wdata),
    .raddr_i(roff[IW+1:2]),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alive_q  <= 1'b0;
      rs_q     <= R_IDLE;
      raddr_q  <= '0;
      rid_q    <= '0;
      rlen_q   <= '0;
      rcnt_q   <= '0;
      rburst_q <= '0;
      rlat_q   <= '0;
      ws_q     <= W_IDLE;
      waddr_q  <= '0;
      wid_q    <= '0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      wburst_q <= '0;
      werr_q   <= 1'b0;
    end else begin
      alive_q  <= 1'b1;
      rs_q     <= rs_d;
      raddr_q  <= raddr_d;
      rid_q    <= rid_d;
      rlen_q   <= rlen_d;
      rcnt_q   <= rcnt_d;
      rburst_q <= rburst_d;
      rlat_q   <= rlat_d;
      ws_q     <= ws_d;
      waddr_q  <= waddr_d;
      wid_q    <= wid_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      wburst_q <= wburst_d;
      werr_q   <= werr_d;
    end
  end

  // R_WAIT is entered even for zero latency so the first beat always
  // appears RD_LATENCY+1 edges after the AR handshake.
  always_comb begin
    rs_d             = rs_q;
    raddr_d          = raddr_q;
    rid_d            = rid_q;
    rlen_d           = rlen_q;
    rcnt_d           = rcnt_q;
    rburst_d         = rburst_q;
    rlat_d           = rlat_q;
    io_slave_arready = 1'b0;
    io_slave_rvalid  = 1'b0;
    io_slave_rlast   = 1'b0;
    io_slave_rresp   = RESP_OKAY;
    io_slave_rdata   = '0;
    unique case (rs_q)
      R_IDLE: begin
        io_slave_arready = alive_q;
        if (alive_q && io_slave_arvalid) begin
          raddr_d  = io_slave_araddr;
          rid_d    = io_slave_arid;
          rlen_d   = io_slave_arlen;
          rburst_d = io_slave_arburst;
          rcnt_d   = '0;
          rlat_d   = 4'(RD_LATENCY);
          rs_d     = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rlat_q == '0) rs_d = R_DATA;
        else rlat_d = rlat_q - 4'd1;
      end
      R_DATA: begin
        io_slave_rvalid = 1'b1;
        io_slave_rlast  = (rcnt_q == rlen_q);
        io_slave_rresp  = r_ok ? RESP_OKAY : RESP_SLVERR;
        io_slave_rdata  = r_ok ? mem_rdata : '0;
        if (io_slave_rready) begin
          if (rcnt_q == rlen_q) begin
            rs_d = R_IDLE;
          end else begin
            rcnt_d = rcnt_q + 8'd1;
            if (rburst_q != BURST_FIXED) raddr_d = raddr_q + 32'd4;
          end
        end
      end
      default: rs_d = R_IDLE;
    endcase
  end

  assign io_slave_rid = rid_q;
  assign io_slave_bid = wid_q;
  assign w_last       = (wcnt_q == wlen_q);
  assign mem_we       = (ws_q == W_DATA) && io_slave_wvalid && w_ok;

  always_comb begin
    ws_d             = ws_q;
    waddr_d          = waddr_q;
    wid_d            = wid_q;
    wlen_d           = wlen_q;
    wcnt_d           = wcnt_q;
    wburst_d         = wburst_q;
    werr_d           = werr_q;
    io_slave_awready = 1'b0;
    io_slave_wready  = 1'b0;
    io_slave_bvalid  = 1'b0;
    io_slave_bresp   = RESP_OKAY;
    unique case (ws_q)
      W_IDLE: begin
        io_slave_awready = alive_q;
        if (alive_q && io_slave_awvalid) begin
          waddr_d  = io_slave_awaddr;
          wid_d    = io_slave_awid;
          wlen_d   = io_slave_awlen;
          wburst_d = io_slave_awburst;
          wcnt_d   = '0;
          werr_d   = 1'b0;
          ws_d     = W_DATA;
        end
      end
      W_DATA: begin
        io_slave_wready = 1'b1;
        if (io_slave_wvalid) begin
          // Beat count, not wlast, decides where the burst ends.
          if (!w_ok || (io_slave_wlast != w_last)) werr_d = 1'b1;
          if (w_last) begin
            ws_d = W_RESP;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
            if (wburst_q != BURST_FIXED) waddr_d = waddr_q + 32'd4;
          end
        end
      end
      W_RESP: begin
        io_slave_bvalid = 1'b1;
        io_slave_bresp  = werr_q ? RESP_SLVERR : RESP_OKAY;
        if (io_slave_bready) ws_d = W_IDLE;
      end
      default: ws_d = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed self-checking bench for axi_sram_slave (RD_LATENCY=2).
// Drives and samples 1 time unit after each rising edge.
module tb_axi_sram_slave;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        awready, awvalid = 0;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [2:0]  awsize = 3'd2;
  logic [1:0]  awburst = 0;
  logic        wready, wvalid = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bready = 0, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid = 0;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 0;
  logic        rready = 0, rvalid;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [8];
  logic        wl [8];
  logic [3:0]  wsb;
  logic [31:0] rdq [8];
  logic [1:0]  rrq [8];
  logic        rlq [8];
  logic [1:0]  br;
  logic [3:0]  bi;

  always #5 clock = ~clock;

  axi_sram_slave #(
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH_WORDS(4096),
    .RD_LATENCY (2)
  ) dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(awready), .io_slave_awvalid(awvalid),
    .io_slave_awaddr(awaddr), .io_slave_awid(awid),
    .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst),
    .io_slave_wready(wready), .io_slave_wvalid(wvalid),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb),
    .io_slave_wlast(wlast),
    .io_slave_bready(bready), .io_slave_bvalid(bvalid),
    .io_slave_bresp(bresp), .io_slave_bid(bid),
    .io_slave_arready(arready), .io_slave_arvalid(arvalid),
    .io_slave_araddr(araddr), .io_slave_arid(arid),
    .io_slave_arlen(arlen), .io_slave_arsize(arsize),
    .io_slave_arburst(arburst),
    .io_slave_rready(rready), .io_slave_rvalid(rvalid),
    .io_slave_rresp(rresp), .io_slave_rdata(rdata),
    .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ar_hs(input logic [31:0] a, input logic [3:0] id,
                       input logic [7:0] len, input logic [1:0] bu);
    logic s;
    int n;
    araddr = a; arid = id; arlen = len; arburst = bu; arvalid = 1;
    n = 0;
    do begin s = arready; tick(); n++; end while (!s && n < 50);
    arvalid = 0;
    if (!s) chk("ar_timeout", 32'(s), 32'd1);
  endtask

  task automatic wait_rvalid();
    int n;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    if (!rvalid) chk("r_timeout", 32'(rvalid), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len, input logic [1:0] bu,
                    output logic [1:0] resp, output logic [3:0] bidv);
    logic s;
    int n;
    awaddr = a; awid = id; awlen = len; awburst = bu; awvalid = 1;
    n = 0;
    do begin s = awready; tick(); n++; end while (!s && n < 50);
    awvalid = 0;
    if (!s) chk("aw_timeout", 32'(s), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = wsb; wlast = wl[i];
      n = 0;
      do begin s = wready; tick(); n++; end while (!s && n < 50);
      if (!s) chk("w_timeout", 32'(s), 32'd1);
    end
    wvalid = 0; wlast = 0;
    bready = 1;
    n = 0;
    do begin
      s = bvalid; resp = bresp; bidv = bid; tick(); n++;
    end while (!s && n < 50);
    bready = 0;
    if (!s) chk("b_timeout", 32'(s), 32'd1);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] strb);
    wd[0] = d; wl[0] = 1; wsb = strb;
    wr(a, 4'd0, 8'd0, 2'b01, br, bi);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] len,
                    input logic [1:0] bu);
    ar_hs(a, 4'd1, len, bu);
    rready = 1;
    for (int i = 0; i <= int'(len); i++) begin
      wait_rvalid();
      rdq[i] = rdata; rrq[i] = rresp; rlq[i] = rlast;
      tick();
    end
    rready = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin wd[i] = 0; wl[i] = 0; end
    wsb = 4'hF;
    // Reset state
    tick(); tick();
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids", {24'd0, rid, bid}, 0);
    chk("rst_resps", {28'd0, rresp, bresp}, 0);
    reset = 1;
    tick();
    chk("rel_arready", 32'(arready), 1);
    chk("rel_awready", 32'(awready), 1);

    // Single write then latency-checked read
    wd[0] = 32'hDEADBEEF; wl[0] = 1; wsb = 4'hF;
    wr(32'h8000_0004, 4'd3, 8'd0, 2'b01, br, bi);
    chk("w1_bresp", 32'(br), 0);
    chk("w1_bid", 32'(bi), 3);
    chk("w_awready_back", 32'(awready), 1);
    araddr = 32'h8000_0004; arid = 4'd5; arlen = 0;
    arburst = 2'b01; arvalid = 1;
    tick();
    arvalid = 0;
    chk("lat_arready_lo", 32'(arready), 0);
    chk("lat_n0", 32'(rvalid), 0);
    tick();
    chk("lat_n1", 32'(rvalid), 0);
    tick();
    chk("lat_n2", 32'(rvalid), 0);
    tick();
    chk("lat_n3", 32'(rvalid), 1);
    chk("r1_rdata", rdata, 32'hDEADBEEF);
    chk("r1_rresp", 32'(rresp), 0);
    chk("r1_rlast", 32'(rlast), 1);
    chk("r1_rid", 32'(rid), 5);
    rready = 1;
    tick();
    rready = 0;
    chk("r1_done", 32'(rvalid), 0);
    chk("r1_arready", 32'(arready), 1);

    // INCR burst of 4 with a mid-burst stall
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; wl[i] = (i == 3); end
    wsb = 4'hF;
    wr(32'h8000_0010, 4'd2, 8'd3, 2'b01, br, bi);
    chk("incr_bresp", 32'(br), 0);
    ar_hs(32'h8000_0010, 4'd7, 8'd3, 2'b01);
    wait_rvalid();
    rready = 1;
    chk("b0_data", rdata, 1);
    chk("b0_last", 32'(rlast), 0);
    tick();
    chk("b1_data", rdata, 2);
    chk("b1_last", 32'(rlast), 0);
    tick();
    rready = 0;
    chk("b2_data", rdata, 3);
    tick();
    chk("stall1_valid", 32'(rvalid), 1);
    chk("stall1_data", rdata, 3);
    tick();
    chk("stall2_valid", 32'(rvalid), 1);
    chk("stall2_data", rdata, 3);
    chk("b2_last", 32'(rlast), 0);
    rready = 1;
    tick();
    chk("b3_data", rdata, 4);
    chk("b3_last", 32'(rlast), 1);
    tick();
    rready = 0;
    chk("incr_end", 32'(rvalid), 0);

    // Byte strobes
    wr1(32'h8000_0020, 32'hFFFFFFFF, 4'hF);
    wr1(32'h8000_0020, 32'h11223344, 4'b0101);
    rd(32'h8000_0020, 8'd0, 2'b01);
    chk("strb_data", rdq[0], 32'hFF22FF44);

    // Out-of-range accesses
    wr1(32'h8000_0000, 32'hA5A5A5A5, 4'hF);
    rd(32'h7FFF_FFFC, 8'd0, 2'b01);
    chk("oob_rresp", 32'(rrq[0]), 2);
    chk("oob_rdata", rdq[0], 0);
    wr1(32'h8000_4000, 32'h55555555, 4'hF);
    chk("oob_bresp", 32'(br), 2);
    rd(32'h8000_0000, 8'd0, 2'b01);
    chk("oob_mem", rdq[0], 32'hA5A5A5A5);
    chk("oob_mem_resp", 32'(rrq[0]), 0);

    // Early wlast: both beats land, response is SLVERR
    wd[0] = 32'h7; wd[1] = 32'h8; wl[0] = 1; wl[1] = 0; wsb = 4'hF;
    wr(32'h8000_0030, 4'd4, 8'd1, 2'b01, br, bi);
    chk("wlast_bresp", 32'(br), 2);
    chk("wlast_bid", 32'(bi), 4);
    rd(32'h8000_0030, 8'd1, 2'b01);
    chk("wlast_b0", rdq[0], 7);
    chk("wlast_b1", rdq[1], 8);
    chk("wlast_rlast", {30'd0, rlq[0], rlq[1]}, 1);

    // FIXED write burst
    wr1(32'h8000_0044, 32'h12345678, 4'hF);
    wd[0] = 32'h9; wd[1] = 32'hA; wd[2] = 32'hB;
    wl[0] = 0; wl[1] = 0; wl[2] = 1; wsb = 4'hF;
    wr(32'h8000_0040, 4'd6, 8'd2, 2'b00, br, bi);
    chk("fixed_bresp", 32'(br), 0);
    rd(32'h8000_0040, 8'd1, 2'b01);
    chk("fixed_word", rdq[0], 32'hB);
    chk("fixed_next", rdq[1], 32'h12345678);

    // Reset during R_DATA
    ar_hs(32'h8000_0010, 4'd9, 8'd3, 2'b01);
    wait_rvalid();
    chk("pre_rst_valid", 32'(rvalid), 1);
    reset = 0;
    #1;
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_arready", 32'(arready), 0);
    tick();
    reset = 1;
    tick();
    chk("post_rst_arready", 32'(arready), 1);
    rd(32'h8000_0010, 8'd3, 2'b01);
    chk("keep_b0", rdq[0], 1);
    chk("keep_b3", rdq[3], 4);
    chk("keep_last", {28'd0, rlq[0], rlq[1], rlq[2], rlq[3]}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
